conv3x3_window_mac: RTL

- Compute engine directly downstream of the conv2D address controller; performs one 3x3 convolution window per request.
- On each `en` request it takes the kernel base address (memory A) and the image window base address (memory B) from the controller.
- It fetches 9 kernel weights and 9 image pixels from synchronous-read RAMs, forms a signed multiply-accumulate, and returns the sum with a one-cycle `done` pulse.
- It then waits for the controller's `ack` before accepting the next window.

---
 rtl/conv3x3_window_mac.sv | 115 +++++++++++
 1 files changed

// File: rtl/conv3x3_window_mac.sv
// 3x3 signed multiply-accumulate over one kernel/image window per request.
// Reads both operand RAMs (1-cycle latency) and returns the sum with a done/ack handshake.
module conv3x3_window_mac #(
  parameter int IMG_W    = 48,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int A_ADDR_W = 4,
  parameter int B_ADDR_W = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [A_ADDR_W-1:0] base_addrA,
  input  logic [B_ADDR_W-1:0] base_addrB,
  input  logic                ack,
  output logic [A_ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0]   dataA,
  output logic [B_ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0]   dataB,
  output logic [ACC_W-1:0]    result,
  output logic                done,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DONE, WAIT_ACK} state_t;

  state_t                     state, state_nxt;
  logic [A_ADDR_W-1:0]        base_a;
  logic [B_ADDR_W-1:0]        base_b;
  logic [B_ADDR_W-1:0]        row_off, row_off_nxt;
  logic [1:0]                 col, col_nxt;
  logic [3:0]                 k;
  logic [1:0]                 vld;
  logic                       issue;
  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = $signed(dataA) * $signed(dataB);
  assign prod_ext = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
  assign busy     = (state != IDLE);
  assign issue    = ((state == IDLE) && en) || (state == FETCH);

  // Window walk: column 0..2, then step one image row down
  always_comb begin
    col_nxt     = col + 2'd1;
    row_off_nxt = row_off;
    if (col == 2'd2) begin
      col_nxt     = 2'd0;
      row_off_nxt = row_off + B_ADDR_W'(IMG_W);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en) state_nxt = FETCH;
      FETCH:    if (k == 4'd7) state_nxt = DRAIN;
      DRAIN:    if (!vld[0]) state_nxt = DONE;
      DONE:     state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // vld tracks taps in flight; a product is ready two edges after its address
  always_ff @(posedge clk) begin
    if (rst) begin
      base_a  <= '0;
      base_b  <= '0;
      row_off <= '0;
      col     <= '0;
      k       <= '0;
      vld     <= '0;
      acc     <= '0;
      addrA   <= '0;
      addrB   <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      vld  <= {vld[0], issue};
      done <= (state == DONE);
      if (vld[1]) acc <= acc + prod_ext;
      case (state)
        IDLE: begin
          if (en) begin
            base_a  <= base_addrA;
            base_b  <= base_addrB;
            row_off <= '0;
            col     <= '0;
            k       <= '0;
            acc     <= '0;
            addrA   <= base_addrA;
            addrB   <= base_addrB;
          end
        end
        FETCH: begin
          k       <= k + 4'd1;
          col     <= col_nxt;
          row_off <= row_off_nxt;
          addrA   <= base_a + A_ADDR_W'(k + 4'd1);
          addrB   <= base_b + row_off_nxt + B_ADDR_W'(col_nxt);
        end
        DONE:    result <= acc;
        default: ;
      endcase
    end
  end

endmodule
